// File: rtl/spi_ram_pkg.sv
// Shared opcodes, default widths and the optional parity width for the SPI command RAM.
// SPI_RAM_PARITY_EN adds one even-parity bit to every stored word.
package spi_ram_pkg;

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_WR_ADDR = 2'b00;
  localparam cmd_t CMD_WR_DATA = 2'b01;
  localparam cmd_t CMD_RD_ADDR = 2'b10;
  localparam cmd_t CMD_RD_DATA = 2'b11;

  localparam int DEF_MEM_DEPTH  = 256;
  localparam int DEF_ADDR_SIZE  = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TX_HOLD    = 10;

`ifdef SPI_RAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

endpackage

// File: rtl/spi_ram_array.sv
// Single-port storage: synchronous write, combinational read so the command edge can latch data.
// Addresses at or beyond DEPTH are ignored on write and read back as zero.
module spi_ram_array #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic              in_range;

  assign in_range = 32'(addr) < DEPTH;

  always_ff @(posedge clk) begin
    if (we && in_range) mem[addr] <= wdata;
  end

  assign rdata = in_range ? mem[addr] : '0;

endmodule

// File: rtl/spi_ram_cmd.sv
// Command-decoding RAM behind the SPI slave: address/data opcodes in, held read data out.
// SPI_RAM_PARITY_EN stores even parity per word and flags mismatches on read.
module spi_ram_cmd
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TX_HOLD    = DEF_TX_HOLD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  parity_err
);

  localparam int WORD_W = DATA_WIDTH + PAR_W;
  localparam int CNT_W  = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(TX_HOLD - 1);

  cmd_t                  cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic [ADDR_SIZE-1:0]  wr_addr;
  logic [ADDR_SIZE-1:0]  rd_addr;
  logic [ADDR_SIZE-1:0]  arr_addr;
  logic [WORD_W-1:0]     arr_wdata;
  logic [WORD_W-1:0]     arr_rdata;
  logic                  arr_we;
  logic                  rd_cmd;
  logic [CNT_W-1:0]      hold_cnt;

  assign cmd     = cmd_t'(din[DATA_WIDTH+1:DATA_WIDTH]);
  assign payload = din[DATA_WIDTH-1:0];

  always_comb begin
    arr_we   = rx_valid && (cmd == CMD_WR_DATA);
    rd_cmd   = rx_valid && (cmd == CMD_RD_DATA);
    arr_addr = arr_we ? wr_addr : rd_addr;
  end

`ifdef SPI_RAM_PARITY_EN
  assign arr_wdata = {^payload, payload};
`else
  assign arr_wdata = payload;
`endif

  spi_ram_array #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (ADDR_SIZE),
    .WORD_W (WORD_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else if (rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: wr_addr <= payload[ADDR_SIZE-1:0];
        CMD_RD_ADDR: rd_addr <= payload[ADDR_SIZE-1:0];
        default: ;
      endcase
    end
  end

  // A new read restarts the hold window; otherwise count down and drop at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      tx_valid <= 1'b0;
      hold_cnt <= '0;
    end else if (rd_cmd) begin
      dout     <= arr_rdata[DATA_WIDTH-1:0];
      tx_valid <= 1'b1;
      hold_cnt <= HOLD_INIT;
    end else if (tx_valid) begin
      if (hold_cnt == '0) tx_valid <= 1'b0;
      else                hold_cnt <= hold_cnt - 1'b1;
    end
  end

`ifdef SPI_RAM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      parity_err <= 1'b0;
    else if (rd_cmd) parity_err <= (^arr_rdata[DATA_WIDTH-1:0]) != arr_rdata[DATA_WIDTH];
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ram_cmd.sv
// Self-checking bench for spi_ram_cmd: directed scenarios plus random command traffic.
// Under SPI_RAM_PARITY_EN a stored parity bit is corrupted to exercise parity_err.
module tb_spi_ram_cmd;
  localparam int TX_HOLD = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] dout;
  logic       tx_valid;
  logic       parity_err;

  int checks = 0;
  int failures = 0;

  spi_ram_cmd dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .rx_valid   (rx_valid),
    .dout       (dout),
    .tx_valid   (tx_valid),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Reference model: remaining-valid-cycles count instead of a hold counter.
  logic [7:0] ref_mem [256];
  logic       ref_par [256];
  logic [7:0] m_wr, m_rd, m_dout;
  logic       m_perr;
  int         m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr = '0; m_rd = '0; m_dout = '0; m_perr = 1'b0; m_left = 0;
    end else begin
      if (m_left > 0) m_left = m_left - 1;
      if (rx_valid) begin
        case (din[9:8])
          2'b00: m_wr = din[7:0];
          2'b01: begin ref_mem[m_wr] = din[7:0]; ref_par[m_wr] = ^din[7:0]; end
          2'b10: m_rd = din[7:0];
          default: begin
            m_dout = ref_mem[m_rd];
            m_perr = (^ref_mem[m_rd]) != ref_par[m_rd];
            m_left = TX_HOLD;
          end
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_tx_valid", 32'(tx_valid), 32'(m_left > 0));
      check("cmp_dout", 32'(dout), 32'(m_dout));
`ifdef SPI_RAM_PARITY_EN
      check("cmp_parity_err", 32'(parity_err), 32'(m_perr));
`else
      check("cmp_parity_err", 32'(parity_err), 32'd0);
`endif
    end
  end

  // Called just after a negedge; presents one word for exactly one rising edge.
  task automatic send(input logic [1:0] op, input logic [7:0] pl);
    din = {op, pl};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    din = 10'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts cycles tx_valid stays high from the current negedge, bounded.
  task automatic count_hold(output int n);
    n = 0;
    while (tx_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    idle(2);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_tx_valid", 32'(tx_valid), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    cmp_en = 1'b1;
    rst_n = 1'b1;
    idle(1);

    for (int a = 0; a < 256; a++) begin
      send(2'b00, 8'(a));
      send(2'b01, 8'($urandom));
    end
    send(2'b00, 8'h00); send(2'b01, 8'hC3);

    // Write then read back with exact hold length.
    send(2'b00, 8'h3C); send(2'b01, 8'hA5);
    send(2'b00, 8'h3D); send(2'b01, 8'h5A);
    send(2'b10, 8'h3C); send(2'b11, 8'h00);
    check("wr_rd_dout", 32'(dout), 32'hA5);
    count_hold(n);
    check("wr_rd_hold_len", 32'(n), 32'd10);

    // Back-to-back reads four cycles apart.
    send(2'b11, 8'h00);
    idle(1);
    send(2'b10, 8'h3D);
    idle(1);
    send(2'b11, 8'h00);
    check("b2b_dout", 32'(dout), 32'h5A);
    count_hold(n);
    check("b2b_hold_len", 32'(n), 32'd10);

    // Same-address write then read on consecutive pulses.
    send(2'b00, 8'h10); send(2'b01, 8'h77);
    send(2'b10, 8'h10); send(2'b11, 8'h00);
    check("same_addr_dout", 32'(dout), 32'h77);

    // Non-read opcode during hold does not disturb the countdown.
    idle(12);
    send(2'b11, 8'h00);
    idle(1);
    send(2'b00, 8'h20);
    count_hold(n);
    check("hold_wr_addr_len", 32'(n), 32'd8);
    send(2'b01, 8'h33); send(2'b10, 8'h20); send(2'b11, 8'h00);
    check("hold_wr_addr_dout", 32'(dout), 32'h33);

    // Asynchronous reset mid-hold.
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_tx_valid", 32'(tx_valid), 32'h0);
    check("midreset_dout", 32'(dout), 32'h0);
    check("midreset_parity_err", 32'(parity_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(2'b11, 8'h00);
    check("post_reset_rd0", 32'(dout), 32'hC3);

    // Parity corruption.
    send(2'b00, 8'h50); send(2'b01, 8'h01);
    idle(1);
`ifdef SPI_RAM_PARITY_EN
    dut.u_array.mem[8'h50][8] = ~dut.u_array.mem[8'h50][8];
    ref_par[8'h50] = ~ref_par[8'h50];
`endif
    send(2'b10, 8'h50); send(2'b11, 8'h00);
    check("parity_dout", 32'(dout), 32'h01);
`ifdef SPI_RAM_PARITY_EN
    check("parity_err_set", 32'(parity_err), 32'h1);
`else
    check("parity_err_tied", 32'(parity_err), 32'h0);
`endif
    send(2'b01, 8'h01);
    idle(12);

    // Random traffic with one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      if ($urandom_range(1, 0) == 1) send(2'($urandom), 8'($urandom));
      else idle(1);
    end
    idle(TX_HOLD + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_ram_cmd.md
Name: spi_ram_cmd

Overview:
- Command-decoding single-port RAM directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data/rx_valid word stream: 2-bit opcode plus 8-bit payload.
- Returns read data to the slave on tx_data/tx_valid for serialisation onto MISO.
- Holds the write and read address registers and the memory array.

Parameters:
- MEM_DEPTH, 256, number of words in the array
- ADDR_SIZE, 8, address width; MEM_DEPTH must be <= 2**ADDR_SIZE
- DATA_WIDTH, 8, word width; equals the payload width of din
- TX_HOLD, 10, cycles tx_valid stays high after a read-data command; covers the slave's 8-bit shift-out plus margin

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  10  command word from the SPI slave; din[9:8] is the opcode, din[7:0] is the payload
- rx_valid  in  1  din valid; single-cycle pulse per word
- dout  out  8  read data to the SPI slave (tx_data)
- tx_valid  out  1  dout valid; held for TX_HOLD cycles
- parity_err  out  1  read-data parity mismatch flag; only meaningful with the optional feature

Behaviour:
- Reset (async, rst_n low):
  - dout=0, tx_valid=0, parity_err=0.
  - wr_addr=0, rd_addr=0, hold counter=0.
  - Memory contents are not reset.
- Opcodes are decoded only on a clk edge where rx_valid=1; all other cycles are ignored.
- 2'b00 WR_ADDR: wr_addr <= din[7:0].
- 2'b01 WR_DATA:
  - mem[wr_addr] <= din[7:0] at the same edge.
  - wr_addr does not auto-increment.
- 2'b10 RD_ADDR: rd_addr <= din[7:0].
- 2'b11 RD_DATA:
  - din[7:0] is a don't-care.
  - At the same edge: dout <= mem[rd_addr], tx_valid <= 1, hold counter <= TX_HOLD-1.
  - Visible in the next cycle (latency 1).
- tx_valid hold:
  - While tx_valid=1 the counter decrements each cycle.
  - When the counter reaches 0 with no new RD_DATA, tx_valid <= 0 on the next edge.
  - dout holds its value until the next RD_DATA.
- Address range: an address >= MEM_DEPTH is dropped modulo 2**ADDR_SIZE.
  - WR_DATA to an out-of-range address: no write.
  - RD_DATA from an out-of-range address: dout=0.
- RD_DATA while tx_valid is already high: dout reloads, counter restarts at TX_HOLD-1, tx_valid stays 1 with no gap.
- Other opcodes while tx_valid is high: executed normally; the hold countdown continues undisturbed.
- WR_DATA then RD_DATA to the same address on consecutive pulses returns the new data (the write is complete at its edge).
- Reset mid-hold: tx_valid drops asynchronously; addresses return to 0.
- No back-pressure: every rx_valid pulse is accepted.

Optional Feature:
- Macro: SPI_RAM_PARITY_EN.
- When defined:
  - The array is DATA_WIDTH+1 wide; WR_DATA stores even parity (^din[7:0]) in the extra bit.
  - RD_DATA recomputes parity; parity_err <= mismatch at the same edge as dout, held with dout.
- When undefined: the array is DATA_WIDTH wide and parity_err is tied 0.
- The port list is identical in both builds.

Decomposition:
- Package spi_ram_pkg:
  - Opcode localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - typedef cmd_t (2-bit) and the default width constants.
- One sub-module is natural: spi_ram_array.
  - Plain synchronous single-port storage: we, addr, wdata, rdata.
  - Carries the parity bit width under the macro.
- Command decode and tx-hold logic stay in spi_ram_cmd.

Test Plan:
- Reset: assert rst_n=0 mid-run with tx_valid=1 -> dout=0, tx_valid=0, parity_err=0 immediately; a subsequent RD_DATA with no address written reads mem[0].
- Write/read: din=10'h0_3C (00, WR_ADDR 0x3C), then 10'h1_A5 (01, WR_DATA), then 10'h2_3C (10, RD_ADDR), then 10'h3_00 (11, RD_DATA) -> next cycle dout=8'hA5, tx_valid=1 for exactly 10 cycles, then 0.
- Back-to-back reads: RD_DATA at 0x3C, then RD_DATA at 0x3D (written 0x5A) 4 cycles later -> dout switches to 8'h5A, tx_valid continuous, drops 10 cycles after the second command.
- Same-address write-then-read on consecutive rx_valid pulses: WR 0x77 to 0x10, set rd_addr=0x10, RD_DATA -> dout=8'h77.
- Non-read opcode during hold: WR_ADDR 0x20 issued in cycle 3 of hold -> tx_valid still drops at cycle 10; wr_addr=0x20.
- Parity (SPI_RAM_PARITY_EN): write 0x01, force-flip the stored parity bit via hierarchical deposit, RD_DATA -> parity_err=1 with dout=8'h01; without the macro, parity_err stays 0.
